// File: rtl/addsub_fu.sv
// addsub_fu: tagged add/subtract functional unit for the Tomasulo cluster.
// Two-stage datapath (operand condition/invert, then add with carry-in),
// followed by a circular result queue that is drained onto the common data
// bus under a request/grant handshake. A credit counter covering E1, E2 and
// the queue keeps the pipeline stall-free: every accepted op owns a slot.

module addsub_fu #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [1:0]       issue_op,
   input  logic [TAG_W-1:0] issue_tag,
   input  logic [WIDTH-1:0] issue_a,
   input  logic [WIDTH-1:0] issue_b,
   output logic             cdb_req,
   input  logic             cdb_grant,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [WIDTH-1:0] cdb_data,
   output logic             cdb_ovf
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_RSUB = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // Occupancy view of the credit counter; only visible through ready/req.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_FULL = 2'b10
   } status_t;

   // x + y' + cin truncated to WIDTH; the carry-out is intentionally dropped.
   function automatic logic [WIDTH-1:0] add_cin(
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y,
      input logic             cin
   );
      return x + y + WIDTH'(cin);
   endfunction

   // Two's-complement overflow: like-signed inputs producing a sum of the
   // other sign. PASS never overflows.
   function automatic logic signed_ovf(
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y,
      input logic [WIDTH-1:0] sum,
      input logic             pass
   );
      return !pass && (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
   endfunction

   // Advance a queue pointer, wrapping modulo DEPTH (DEPTH need not be 2^n).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
   endfunction

   // ---------------- state ----------------
   logic             e1_valid_q, e1_valid_d;
   logic [WIDTH-1:0] e1_x_q,     e1_x_d;
   logic [WIDTH-1:0] e1_y_q,     e1_y_d;
   logic             e1_cin_q,   e1_cin_d;
   logic             e1_pass_q,  e1_pass_d;
   logic [TAG_W-1:0] e1_tag_q,   e1_tag_d;

   logic             e2_valid_q, e2_valid_d;
   logic [WIDTH-1:0] e2_sum_q,   e2_sum_d;
   logic             e2_ovf_q,   e2_ovf_d;
   logic [TAG_W-1:0] e2_tag_q,   e2_tag_d;

   logic [WIDTH-1:0] q_data_q [DEPTH];
   logic [WIDTH-1:0] q_data_d [DEPTH];
   logic [TAG_W-1:0] q_tag_q  [DEPTH];
   logic [TAG_W-1:0] q_tag_d  [DEPTH];
   logic             q_ovf_q  [DEPTH];
   logic             q_ovf_d  [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   // ---------------- combinational control ----------------
   status_t          status;
   logic [CNT_W-1:0] q_used;
   logic             accept;
   logic             pop;
   logic             wr_en;
   logic [WIDTH-1:0] e1_sum;

   // Classify the credit counter into idle / busy / full.
   always_comb begin
      status = ST_BUSY;
      if (cnt_q == {CNT_W{1'b0}}) begin
         status = ST_IDLE;
      end else if (cnt_q == CNT_FULL) begin
         status = ST_FULL;
      end else begin
         status = ST_BUSY;
      end
   end

   // Handshake decode: queue occupancy, ready, accept, pop and queue write.
   always_comb begin
      q_used      = cnt_q - CNT_W'(e1_valid_q) - CNT_W'(e2_valid_q);
      cdb_req     = (q_used != {CNT_W{1'b0}});
      // A full unit can still take an op on the edge its head is popped.
      issue_ready = (status != ST_FULL) || (cdb_req && cdb_grant);
      accept      = issue_valid && issue_ready && !flush;
      pop         = cdb_req && cdb_grant && !flush;
      wr_en       = e2_valid_q && !flush;
   end

   // Stage E1 next state: swap/invert operands and choose the carry-in.
   always_comb begin
      e1_valid_d = accept;
      e1_x_d     = e1_x_q;
      e1_y_d     = e1_y_q;
      e1_cin_d   = e1_cin_q;
      e1_pass_d  = e1_pass_q;
      e1_tag_d   = e1_tag_q;
      if (accept) begin
         e1_tag_d = issue_tag;
         case (issue_op)
            OP_ADD: begin
               e1_x_d    = issue_a;
               e1_y_d    = issue_b;
               e1_cin_d  = 1'b0;
               e1_pass_d = 1'b0;
            end
            OP_SUB: begin
               e1_x_d    = issue_a;
               e1_y_d    = ~issue_b;
               e1_cin_d  = 1'b1;
               e1_pass_d = 1'b0;
            end
            OP_RSUB: begin
               e1_x_d    = issue_b;
               e1_y_d    = ~issue_a;
               e1_cin_d  = 1'b1;
               e1_pass_d = 1'b0;
            end
            OP_PASS: begin
               e1_x_d    = issue_a;
               e1_y_d    = {WIDTH{1'b0}};
               e1_cin_d  = 1'b0;
               e1_pass_d = 1'b1;
            end
            default: begin
               e1_x_d    = issue_a;
               e1_y_d    = issue_b;
               e1_cin_d  = 1'b0;
               e1_pass_d = 1'b0;
            end
         endcase
      end else begin
         e1_tag_d = e1_tag_q;
      end
   end

   // Stage E2 next state: the adder and overflow detect on E1's operands.
   always_comb begin
      e1_sum     = add_cin(e1_x_q, e1_y_q, e1_cin_q);
      e2_valid_d = e1_valid_q && !flush;
      if (e1_valid_q) begin
         e2_sum_d = e1_sum;
         e2_ovf_d = signed_ovf(e1_x_q, e1_y_q, e1_sum, e1_pass_q);
         e2_tag_d = e1_tag_q;
      end else begin
         e2_sum_d = e2_sum_q;
         e2_ovf_d = e2_ovf_q;
         e2_tag_d = e2_tag_q;
      end
   end

   // Result queue next state: write E2 at the tail, pop the head, count credits.
   always_comb begin
      q_data_d = q_data_q;
      q_tag_d  = q_tag_q;
      q_ovf_d  = q_ovf_q;
      if (wr_en) begin
         q_data_d[wr_ptr_q] = e2_sum_q;
         q_tag_d[wr_ptr_q]  = e2_tag_q;
         q_ovf_d[wr_ptr_q]  = e2_ovf_q;
         wr_ptr_d           = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         cnt_d    = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);
      end
   end

   // CDB drive: present the queue head, zeros while nothing is requested.
   always_comb begin
      if (cdb_req) begin
         cdb_tag  = q_tag_q[rd_ptr_q];
         cdb_data = q_data_q[rd_ptr_q];
         cdb_ovf  = q_ovf_q[rd_ptr_q];
      end else begin
         cdb_tag  = {TAG_W{1'b0}};
         cdb_data = {WIDTH{1'b0}};
         cdb_ovf  = 1'b0;
      end
   end

   // Pipeline stage registers with asynchronous reset.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         e1_valid_q <= 1'b0;
         e1_x_q     <= {WIDTH{1'b0}};
         e1_y_q     <= {WIDTH{1'b0}};
         e1_cin_q   <= 1'b0;
         e1_pass_q  <= 1'b0;
         e1_tag_q   <= {TAG_W{1'b0}};
         e2_valid_q <= 1'b0;
         e2_sum_q   <= {WIDTH{1'b0}};
         e2_ovf_q   <= 1'b0;
         e2_tag_q   <= {TAG_W{1'b0}};
      end else begin
         e1_valid_q <= e1_valid_d;
         e1_x_q     <= e1_x_d;
         e1_y_q     <= e1_y_d;
         e1_cin_q   <= e1_cin_d;
         e1_pass_q  <= e1_pass_d;
         e1_tag_q   <= e1_tag_d;
         e2_valid_q <= e2_valid_d;
         e2_sum_q   <= e2_sum_d;
         e2_ovf_q   <= e2_ovf_d;
         e2_tag_q   <= e2_tag_d;
      end
   end

   // Result queue storage, pointers and credit counter with asynchronous reset.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_data_q[i] <= {WIDTH{1'b0}};
            q_tag_q[i]  <= {TAG_W{1'b0}};
            q_ovf_q[i]  <= 1'b0;
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         q_data_q <= q_data_d;
         q_tag_q  <= q_tag_d;
         q_ovf_q  <= q_ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_addsub_fu.sv
// Directed self-checking bench for addsub_fu (WIDTH=32, TAG_W=4, DEPTH=2).
module tb_addsub_fu;

   localparam int WIDTH = 32;
   localparam int TAG_W = 4;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             nRST = 1'b1;
   logic             flush;
   logic             issue_valid;
   logic             issue_ready;
   logic [1:0]       issue_op;
   logic [TAG_W-1:0] issue_tag;
   logic [WIDTH-1:0] issue_a;
   logic [WIDTH-1:0] issue_b;
   logic             cdb_req;
   logic             cdb_grant;
   logic [TAG_W-1:0] cdb_tag;
   logic [WIDTH-1:0] cdb_data;
   logic             cdb_ovf;

   int n_total = 0;
   int n_bad   = 0;

   addsub_fu #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .nRST        (nRST),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_tag   (issue_tag),
      .issue_a     (issue_a),
      .issue_b     (issue_b),
      .cdb_req     (cdb_req),
      .cdb_grant   (cdb_grant),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .cdb_ovf     (cdb_ovf)
   );

   always #5 clk = ~clk;

   // Broadcast monitor: records every granted head, tracks ops owned by the unit.
   logic [TAG_W-1:0] mon_tag  [$];
   logic [WIDTH-1:0] mon_data [$];
   logic             mon_ovf  [$];
   int pop_total    = 0;
   int inflight     = 0;
   int max_inflight = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!nRST || flush) begin
            inflight = 0;
         end else begin
            if (cdb_req && cdb_grant) begin
               mon_tag.push_back(cdb_tag);
               mon_data.push_back(cdb_data);
               mon_ovf.push_back(cdb_ovf);
               pop_total++;
            end
            inflight = inflight + ((issue_valid && issue_ready) ? 1 : 0)
                                - ((cdb_req && cdb_grant) ? 1 : 0);
            if (inflight > max_inflight) max_inflight = inflight;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [TAG_W-1:0] t,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      issue_valid = v;
      issue_op    = op;
      issue_tag   = t;
      issue_a     = av;
      issue_b     = bv;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, ".ready"}, issue_ready, 1);
      chk({nm, ".req"},   cdb_req,     0);
      chk({nm, ".tag"},   cdb_tag,     0);
      chk({nm, ".data"},  cdb_data,    0);
      chk({nm, ".ovf"},   cdb_ovf,     0);
   endtask

   // Single op on an idle unit, grant held high; called just after an edge.
   task automatic run_one(input string nm, input logic [1:0] op, input logic [TAG_W-1:0] t,
                          input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] exp_d, input logic exp_o);
      cdb_grant = 1'b1;
      drive(1'b1, op, t, av, bv);
      @(negedge clk);
      chk({nm, ".rdy_issue"}, issue_ready, 1);
      step;                                   // accept edge N
      drive(1'b0, 2'b00, '0, '0, '0);
      @(negedge clk);
      chk({nm, ".req_n1"}, cdb_req, 0);
      chk({nm, ".rdy_n1"}, issue_ready, 1);
      step;                                   // edge N+1
      @(negedge clk);
      chk({nm, ".req_n2"}, cdb_req, 0);
      step;                                   // edge N+2
      @(negedge clk);
      chk({nm, ".req"},  cdb_req,     1);
      chk({nm, ".tag"},  cdb_tag,     t);
      chk({nm, ".data"}, cdb_data,    exp_d);
      chk({nm, ".ovf"},  cdb_ovf,     exp_o);
      chk({nm, ".rdy"},  issue_ready, 1);
      step;                                   // pop
      @(negedge clk);
      chk({nm, ".req_after"}, cdb_req, 0);
   endtask

   // Stream vectors: op, a, b, hand-computed result and overflow.
   logic [1:0]       v_op  [10] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00,
                                    2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
   logic [WIDTH-1:0] v_a   [10] = '{32'd1, 32'd10, 32'd4, 32'h55, 32'hFFFF_FFFF,
                                    32'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd100};
   logic [WIDTH-1:0] v_b   [10] = '{32'd2, 32'd4, 32'd10, 32'h99, 32'd1,
                                    32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'd100};
   logic [WIDTH-1:0] v_exp [10] = '{32'd3, 32'd6, 32'd6, 32'h55, 32'd0,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0};
   logic             v_ovf [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idx;
      int guard;
      int snap;
      logic took;

      flush     = 1'b0;
      cdb_grant = 1'b0;
      drive(1'b0, 2'b00, '0, '0, '0);

      // ---- reset values ----
      #1 nRST = 1'b0;
      #2;
      chk_reset_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #1 nRST = 1'b1;

      // ---- single ops with grant high ----
      run_one("add",    2'b00, 4'd3, 32'd5,          32'd7,      32'd12,         1'b0);
      step;
      run_one("sub",    2'b01, 4'd4, 32'h8000_0000,  32'd1,      32'h7FFF_FFFF,  1'b1);
      step;
      run_one("rsub",   2'b10, 4'd5, 32'd3,          32'd10,     32'd7,          1'b0);
      step;
      run_one("pass",   2'b11, 4'd6, 32'hDEAD_BEEF,  32'h1234,   32'hDEAD_BEEF,  1'b0);
      step;
      run_one("addovf", 2'b00, 4'd7, 32'h7FFF_FFFF,  32'd1,      32'h8000_0000,  1'b1);

      // ---- backpressure: grant low fills the credits ----
      step;
      cdb_grant = 1'b0;
      drive(1'b1, 2'b00, 4'd1, 32'd1, 32'h100);
      @(negedge clk);
      chk("bp.rdy_a", issue_ready, 1);
      step;
      drive(1'b1, 2'b00, 4'd2, 32'd2, 32'h100);
      @(negedge clk);
      chk("bp.rdy_b", issue_ready, 1);
      step;
      drive(1'b1, 2'b00, 4'd3, 32'd3, 32'h100);
      @(negedge clk);
      chk("bp.full0_rdy", issue_ready, 0);
      step;
      @(negedge clk);
      chk("bp.full1_rdy", issue_ready, 0);
      chk("bp.full1_req", cdb_req,     1);
      chk("bp.full1_tag", cdb_tag,     1);
      step;
      @(negedge clk);
      chk("bp.full2_rdy", issue_ready, 0);
      step;
      cdb_grant = 1'b1;
      @(negedge clk);
      chk("bp.grant_rdy", issue_ready, 1);
      chk("bp.grant_tag", cdb_tag,     1);
      chk("bp.grant_dat", cdb_data,    32'h101);
      step;                                   // pop op1, accept op3
      cdb_grant = 1'b0;
      drive(1'b0, 2'b00, '0, '0, '0);
      @(negedge clk);
      chk("bp.p1_req", cdb_req,     1);
      chk("bp.p1_tag", cdb_tag,     2);
      chk("bp.p1_dat", cdb_data,    32'h102);
      chk("bp.p1_rdy", issue_ready, 0);
      step;
      cdb_grant = 1'b1;
      @(negedge clk);
      chk("bp.p2_tag", cdb_tag, 2);
      step;
      @(negedge clk);
      chk("bp.p3_req", cdb_req,  1);
      chk("bp.p3_tag", cdb_tag,  3);
      chk("bp.p3_dat", cdb_data, 32'h103);
      step;
      @(negedge clk);
      chk("bp.drained_req", cdb_req,     0);
      chk("bp.drained_rdy", issue_ready, 1);

      // ---- stream of 10 ops with grant toggling ----
      step;
      cdb_grant = 1'b0;
      mon_tag.delete();
      mon_data.delete();
      mon_ovf.delete();
      max_inflight = 0;
      idx   = 0;
      guard = 0;
      while (idx < 10 && guard < 100) begin
         drive(1'b1, v_op[idx], TAG_W'(idx), v_a[idx], v_b[idx]);
         @(negedge clk);
         took = issue_ready;
         step;
         guard++;
         cdb_grant = ~cdb_grant;
         if (took) idx++;
      end
      drive(1'b0, 2'b00, '0, '0, '0);
      chk("stream.issued", idx, 10);
      while (mon_tag.size() < 10 && guard < 200) begin
         step;
         cdb_grant = ~cdb_grant;
         guard++;
      end
      repeat (4) begin
         step;
         cdb_grant = ~cdb_grant;
      end
      chk("stream.count", mon_tag.size(), 10);
      for (int j = 0; j < mon_tag.size() && j < 10; j++) begin
         chk($sformatf("stream.tag%0d", j), mon_tag[j],  j);
         chk($sformatf("stream.dat%0d", j), mon_data[j], v_exp[j]);
         chk($sformatf("stream.ovf%0d", j), mon_ovf[j],  v_ovf[j]);
      end
      chk("stream.credit_bound", (max_inflight <= DEPTH), 1);

      // ---- flush with ops in E2 and the queue, issue and grant high ----
      cdb_grant = 1'b1;
      drive(1'b1, 2'b00, 4'd1, 32'd1, 32'd1);
      step;
      drive(1'b1, 2'b00, 4'd2, 32'd2, 32'd2);
      step;
      drive(1'b1, 2'b00, 4'd7, 32'd7, 32'd7);
      step;
      flush = 1'b1;
      @(negedge clk);
      chk("flush.pre_req", cdb_req, 1);
      step;                                   // flush edge
      flush = 1'b0;
      drive(1'b0, 2'b00, '0, '0, '0);
      snap = pop_total;
      @(negedge clk);
      chk("flush.req",  cdb_req,     0);
      chk("flush.rdy",  issue_ready, 1);
      chk("flush.data", cdb_data,    0);
      repeat (3) begin
         step;
         @(negedge clk);
         chk("flush.quiet_req", cdb_req, 0);
      end
      chk("flush.no_bcast", pop_total, snap);
      step;
      run_one("postflush", 2'b00, 4'd5, 32'd20, 32'd22, 32'd42, 1'b0);

      // ---- asynchronous reset mid-stream ----
      step;
      cdb_grant = 1'b0;
      drive(1'b1, 2'b00, 4'd8, 32'd1, 32'd1);
      step;
      drive(1'b1, 2'b00, 4'd9, 32'd2, 32'd2);
      step;
      drive(1'b0, 2'b00, '0, '0, '0);
      step;
      @(negedge clk);
      chk("rst.pre_req", cdb_req, 1);
      chk("rst.pre_tag", cdb_tag, 8);
      #2 nRST = 1'b0;
      #1;
      chk_reset_outputs("rst_async");
      @(posedge clk);
      @(posedge clk);
      #1 nRST = 1'b1;
      run_one("postrst", 2'b00, 4'd3, 32'd5, 32'd7, 32'd12, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
